// File: rtl/crt_row_fetch.sv
// rtl/crt_row_fetch.sv - character-row DMA fetcher with ping-pong line banks
//
// Fetches one character row ahead of the display over a drq/dack handshake
// into fetch bank F while the pixel pipeline reads display bank D = ~F.
// Supports bursts with programmable idle gaps, transparent field attributes
// (the char following an attribute goes to a per-bank FIFO), and sticky
// underrun / FIFO-overflow status.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   enable          DMA enable; low forces drq low and freezes the FSM
//   cfg_cols        columns per row minus one
//   cfg_burst       chars per burst = 2^cfg_burst
//   cfg_gap         gap code g; idle clocks between bursts = 8g-1 (0 if g=0)
//   cfg_fill        1 = normal attribute fill, 0 = transparent attributes
//   frame_start     restart screen fetch
//   row_start       swap banks, begin next row fetch
//   drq / dack      DMA request (registered) / acknowledge
//   ichar           DMA data
//   rd_pos/rd_char  display read column / registered display-bank char
//   attr_pop        pop display-bank attribute FIFO
//   attr_char       registered popped FIFO char
//   underrun        sticky: row swapped before fetch complete
//   fifo_ovf        sticky: FIFO write while full
//   scr_stop        end-of-screen code seen this frame
//   clr_status      clears underrun and fifo_ovf

module crt_row_fetch #(
    parameter int COLS_MAX   = 80,
    parameter int COL_W      = 7,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [COL_W-1:0] cfg_cols,
    input  logic [1:0]       cfg_burst,
    input  logic [2:0]       cfg_gap,
    input  logic             cfg_fill,
    input  logic             frame_start,
    input  logic             row_start,
    output logic             drq,
    input  logic             dack,
    input  logic [7:0]       ichar,
    input  logic [COL_W-1:0] rd_pos,
    output logic [7:0]       rd_char,
    input  logic             attr_pop,
    output logic [6:0]       attr_char,
    output logic             underrun,
    output logic             fifo_ovf,
    output logic             scr_stop,
    input  logic             clr_status
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] FIFO_FULL_CNT = FIFO_DEPTH[FIFO_AW:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic                 f_bank;
    logic                 d_bank;
    logic [COL_W:0]       len [2];
    logic [7:0]           bank_mem [2][COLS_MAX];
    logic [6:0]           fifo_mem [2][FIFO_DEPTH];
    logic [FIFO_AW-1:0]   fifo_wptr [2];
    logic [FIFO_AW-1:0]   fifo_rptr [2];
    logic [FIFO_AW:0]     fifo_cnt [2];
    logic                 prev_attr;

    logic [3:0]           burst_cnt, burst_cnt_next;
    logic [5:0]           gap_cnt, gap_cnt_next;
    logic                 drq_next;

    logic                 xfer;
    logic                 is_stop;
    logic                 to_fifo;
    logic                 store;
    logic                 fifo_full;
    logic                 ovf_set;
    logic                 pop_hit;
    logic                 row_full;
    logic [COL_W:0]       len_f;
    logic [COL_W:0]       len_inc;
    logic [COL_W:0]       row_len;
    logic [3:0]           burst_load;
    logic [5:0]           gap_load;

    always_comb begin
        d_bank     = ~f_bank;
        len_f      = len[f_bank];
        len_inc    = len_f + (COL_W+1)'(1);
        row_len    = {1'b0, cfg_cols} + (COL_W+1)'(1);
        row_full   = (len_inc == row_len);
        burst_load = 4'd1 << cfg_burst;
        gap_load   = {cfg_gap, 3'b000} - 6'd1;
        // Transfers colliding with a frame/row restart are dropped.
        xfer       = drq & dack & (state == S_REQ) & ~frame_start & ~row_start;
        is_stop    = (ichar[7:4] == 4'hF) & ichar[0];
        // Stop codes are always stored, even straight after an attribute.
        to_fifo    = ~is_stop & ~cfg_fill & prev_attr;
        store      = xfer & ~to_fifo;
        fifo_full  = (fifo_cnt[f_bank] == FIFO_FULL_CNT);
        ovf_set    = xfer & to_fifo & fifo_full;
        pop_hit    = attr_pop & (fifo_cnt[d_bank] != '0);
    end

    always_comb begin
        state_next     = state;
        burst_cnt_next = burst_cnt;
        gap_cnt_next   = gap_cnt;
        if (frame_start) begin
            state_next     = S_REQ;
            burst_cnt_next = burst_load;
        end else if (row_start) begin
            state_next     = scr_stop ? S_DONE : S_REQ;
            burst_cnt_next = burst_load;
        end else begin
            case (state)
                S_REQ: begin
                    if (xfer) begin
                        if (store && (is_stop || row_full)) begin
                            state_next = S_DONE;
                        end else if (burst_cnt == 4'd1) begin
                            if (cfg_gap != 3'd0) begin
                                state_next   = S_GAP;
                                gap_cnt_next = gap_load;
                            end else begin
                                burst_cnt_next = burst_load;
                            end
                        end else begin
                            burst_cnt_next = burst_cnt - 4'd1;
                        end
                    end
                end
                S_GAP: begin
                    // The gap counter freezes while the DMA is disabled.
                    if (enable) begin
                        if (gap_cnt <= 6'd1) begin
                            state_next     = S_REQ;
                            burst_cnt_next = burst_load;
                        end else begin
                            gap_cnt_next = gap_cnt - 6'd1;
                        end
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
        drq_next = enable & (state_next == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            burst_cnt <= 4'd0;
            gap_cnt   <= 6'd0;
            drq       <= 1'b0;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
            gap_cnt   <= gap_cnt_next;
            drq       <= drq_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_bank       <= 1'b0;
            prev_attr    <= 1'b0;
            rd_char      <= 8'h00;
            attr_char    <= 7'h00;
            underrun     <= 1'b0;
            fifo_ovf     <= 1'b0;
            scr_stop     <= 1'b0;
            len[0]       <= '0;
            len[1]       <= '0;
            fifo_wptr[0] <= '0;
            fifo_wptr[1] <= '0;
            fifo_rptr[0] <= '0;
            fifo_rptr[1] <= '0;
            fifo_cnt[0]  <= '0;
            fifo_cnt[1]  <= '0;
        end else begin
            rd_char <= ({1'b0, rd_pos} < len[d_bank]) ? bank_mem[d_bank][rd_pos] : 8'h00;
            if (attr_pop) begin
                attr_char <= pop_hit ? fifo_mem[d_bank][fifo_rptr[d_bank]] : 7'h00;
            end
            underrun <= (row_start & ~frame_start & (state != S_DONE) & ~scr_stop)
                      | (underrun & ~clr_status);
            fifo_ovf <= ovf_set | (fifo_ovf & ~clr_status);

            if (frame_start) begin
                f_bank       <= 1'b0;
                prev_attr    <= 1'b0;
                scr_stop     <= 1'b0;
                len[0]       <= '0;
                len[1]       <= '0;
                fifo_wptr[0] <= '0;
                fifo_wptr[1] <= '0;
                fifo_rptr[0] <= '0;
                fifo_rptr[1] <= '0;
                fifo_cnt[0]  <= '0;
                fifo_cnt[1]  <= '0;
            end else if (row_start) begin
                // Old display bank becomes the new fetch bank and is emptied;
                // the freshly fetched bank is rewound for display.
                f_bank            <= d_bank;
                prev_attr         <= 1'b0;
                len[d_bank]       <= '0;
                fifo_wptr[d_bank] <= '0;
                fifo_rptr[d_bank] <= '0;
                fifo_cnt[d_bank]  <= '0;
                fifo_rptr[f_bank] <= '0;
            end else begin
                if (pop_hit) begin
                    fifo_rptr[d_bank] <= fifo_rptr[d_bank] + FIFO_AW'(1);
                    fifo_cnt[d_bank]  <= fifo_cnt[d_bank] - (FIFO_AW+1)'(1);
                end
                if (xfer) begin
                    prev_attr <= ~to_fifo & (ichar[7:6] == 2'b10);
                    if (store) begin
                        len[f_bank] <= len_inc;
                        if (is_stop && ichar[1]) begin
                            scr_stop <= 1'b1;
                        end
                    end else if (!fifo_full) begin
                        fifo_wptr[f_bank] <= fifo_wptr[f_bank] + FIFO_AW'(1);
                        fifo_cnt[f_bank]  <= fifo_cnt[f_bank] + (FIFO_AW+1)'(1);
                    end
                end
            end
        end
    end

    // Line and FIFO storage carry no reset so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && store) begin
            bank_mem[f_bank][len_f[COL_W-1:0]] <= ichar;
        end
        if (!reset && xfer && to_fifo && !fifo_full) begin
            fifo_mem[f_bank][fifo_wptr[f_bank]] <= ichar[6:0];
        end
    end

endmodule

// File: tb/tb_crt_row_fetch.sv
// tb/tb_crt_row_fetch.sv - directed self-checking bench for crt_row_fetch

module tb_crt_row_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [6:0] cfg_cols;
    logic [1:0] cfg_burst;
    logic [2:0] cfg_gap;
    logic       cfg_fill;
    logic       frame_start;
    logic       row_start;
    logic       drq;
    logic       dack;
    logic [7:0] ichar;
    logic [6:0] rd_pos;
    logic [7:0] rd_char;
    logic       attr_pop;
    logic [6:0] attr_char;
    logic       underrun;
    logic       fifo_ovf;
    logic       scr_stop;
    logic       clr_status;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [7:0] src [64];

    crt_row_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_cols   (cfg_cols),
        .cfg_burst  (cfg_burst),
        .cfg_gap    (cfg_gap),
        .cfg_fill   (cfg_fill),
        .frame_start(frame_start),
        .row_start  (row_start),
        .drq        (drq),
        .dack       (dack),
        .ichar      (ichar),
        .rd_pos     (rd_pos),
        .rd_char    (rd_char),
        .attr_pop   (attr_pop),
        .attr_char  (attr_char),
        .underrun   (underrun),
        .fifo_ovf   (fifo_ovf),
        .scr_stop   (scr_stop),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Holds dack high and presents src[base+got] until n transfers complete.
    task automatic feed(input int base, input int n, output int got);
        got = 0;
        for (int c = 0; c < 200 && got < n; c++) begin
            dack  = 1'b1;
            ichar = src[base + got];
            if (drq) got++;
            tick();
        end
        dack = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_row();
        row_start = 1'b1;
        tick();
        row_start = 1'b0;
    endtask

    task automatic read_at(input int p);
        rd_pos = 7'(p);
        tick();
    endtask

    initial begin
        int   got;
        int   mism;
        logic exp_drq;

        reset = 1'b1; enable = 1'b1; cfg_cols = 7'd3; cfg_burst = 2'd0; cfg_gap = 3'd0;
        cfg_fill = 1'b1; frame_start = 1'b0; row_start = 1'b0; dack = 1'b0; ichar = 8'h00;
        rd_pos = 7'd0; attr_pop = 1'b0; clr_status = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_drq", 32'(drq), 32'h0);
        check("rst_rd_char", 32'(rd_char), 32'h0);
        check("rst_attr_char", 32'(attr_char), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_fifo_ovf", 32'(fifo_ovf), 32'h0);
        check("rst_scr_stop", 32'(scr_stop), 32'h0);
        tick();
        check("idle_drq", 32'(drq), 32'h0);

        // Basic row fetch
        for (int i = 0; i < 4; i++) src[i] = 8'h41 + 8'(i);
        pulse_frame();
        check("basic_drq_first", 32'(drq), 32'h1);
        feed(0, 4, got);
        check("basic_xfers", 32'(got), 32'd4);
        check("basic_drq_after", 32'(drq), 32'h0);
        tick();
        check("basic_drq_hold", 32'(drq), 32'h0);
        pulse_row();
        check("basic_no_underrun", 32'(underrun), 32'h0);
        for (int p = 0; p < 5; p++) begin
            read_at(p);
            check($sformatf("basic_rd%0d", p), 32'(rd_char), (p < 4) ? 32'h41 + 32'(p) : 32'h0);
        end

        // Burst and gap: 4 on, 7 off, repeated until 16 chars
        cfg_burst = 2'd2; cfg_gap = 3'd1; cfg_cols = 7'd15;
        pulse_frame();
        mism = 0;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            exp_drq = (k < 37) && ((k % 11) < 4);
            if (drq !== exp_drq) mism++;
            dack  = 1'b1;
            ichar = 8'h30 + 8'(got);
            if (drq) got++;
            tick();
        end
        dack = 1'b0;
        check("burst_pattern_mismatches", 32'(mism), 32'd0);
        check("burst_xfers", 32'(got), 32'd16);
        pulse_row();
        read_at(15);
        check("burst_rd15", 32'(rd_char), 32'h3F);
        read_at(4);
        check("burst_rd4", 32'(rd_char), 32'h34);

        // Stop codes
        cfg_burst = 2'd0; cfg_gap = 3'd0; cfg_cols = 7'd7;
        src[0] = 8'h51; src[1] = 8'h52; src[2] = 8'hF1;
        pulse_frame();
        feed(0, 3, got);
        check("eor_drq_low", 32'(drq), 32'h0);
        pulse_row();
        check("eor_no_underrun", 32'(underrun), 32'h0);
        check("eor_next_drq", 32'(drq), 32'h1);
        read_at(2);
        check("eor_rd2", 32'(rd_char), 32'hF1);
        read_at(3);
        check("eor_rd3", 32'(rd_char), 32'h0);
        for (int i = 0; i < 8; i++) src[i] = 8'h60 + 8'(i);
        feed(0, 8, got);
        check("eor_next_xfers", 32'(got), 32'd8);
        check("eor_next_done", 32'(drq), 32'h0);
        pulse_row();
        src[0] = 8'h70; src[1] = 8'hF3;
        feed(0, 2, got);
        check("eos_scr_stop", 32'(scr_stop), 32'h1);
        check("eos_drq_low", 32'(drq), 32'h0);
        pulse_row();
        check("eos_row_no_drq", 32'(drq), 32'h0);
        check("eos_no_underrun", 32'(underrun), 32'h0);
        pulse_row();
        tick();
        check("eos_row2_no_drq", 32'(drq), 32'h0);
        pulse_frame();
        check("eos_frame_clear", 32'(scr_stop), 32'h0);
        check("eos_frame_drq", 32'(drq), 32'h1);

        // Transparent attribute
        cfg_fill = 1'b0; cfg_cols = 7'd2;
        src[0] = 8'h41; src[1] = 8'h85; src[2] = 8'h22; src[3] = 8'h42;
        pulse_frame();
        feed(0, 4, got);
        check("tr_xfers", 32'(got), 32'd4);
        check("tr_done", 32'(drq), 32'h0);
        pulse_row();
        read_at(0);
        check("tr_rd0", 32'(rd_char), 32'h41);
        read_at(1);
        check("tr_rd1", 32'(rd_char), 32'h85);
        read_at(2);
        check("tr_rd2", 32'(rd_char), 32'h42);
        read_at(3);
        check("tr_rd3", 32'(rd_char), 32'h0);
        attr_pop = 1'b1;
        tick();
        attr_pop = 1'b0;
        check("tr_pop1", 32'(attr_char), 32'h22);
        attr_pop = 1'b1;
        tick();
        attr_pop = 1'b0;
        check("tr_pop_empty", 32'(attr_char), 32'h0);

        // Underrun
        cfg_fill = 1'b1; cfg_cols = 7'd3;
        pulse_frame();
        feed(0, 2, got);
        check("ur_before", 32'(underrun), 32'h0);
        pulse_row();
        check("ur_set", 32'(underrun), 32'h1);
        tick();
        tick();
        check("ur_hold", 32'(underrun), 32'h1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("ur_clear", 32'(underrun), 32'h0);

        // Overflow: FIFO_DEPTH+1 attribute pairs
        cfg_fill = 1'b0; cfg_cols = 7'd20;
        for (int i = 0; i < 17; i++) begin
            src[2*i]     = 8'h80 | 8'(i);
            src[2*i + 1] = 8'h10 + 8'(i);
        end
        pulse_frame();
        feed(0, 32, got);
        check("ovf_not_yet", 32'(fifo_ovf), 32'h0);
        feed(32, 2, got);
        check("ovf_set", 32'(fifo_ovf), 32'h1);
        pulse_row();
        mism = 0;
        attr_pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (attr_char !== (7'h10 + 7'(i))) mism++;
        end
        check("ovf_pop_mismatches", 32'(mism), 32'd0);
        tick();
        attr_pop = 1'b0;
        check("ovf_extra_dropped", 32'(attr_char), 32'h0);

        // Reset mid-burst clears status and drq
        cfg_fill = 1'b1; cfg_burst = 2'd2; cfg_gap = 3'd1; cfg_cols = 7'd15;
        pulse_frame();
        feed(0, 2, got);
        check("mid_drq_high", 32'(drq), 32'h1);
        reset = 1'b1;
        dack  = 1'b1;
        tick();
        reset = 1'b0;
        dack  = 1'b0;
        check("mid_rst_drq", 32'(drq), 32'h0);
        check("mid_rst_underrun", 32'(underrun), 32'h0);
        check("mid_rst_fifo_ovf", 32'(fifo_ovf), 32'h0);
        check("mid_rst_scr_stop", 32'(scr_stop), 32'h0);
        check("mid_rst_rd_char", 32'(rd_char), 32'h0);
        tick();
        check("mid_rst_drq_hold", 32'(drq), 32'h0);

        // dack colliding with row_start is dropped
        cfg_burst = 2'd0; cfg_gap = 3'd0; cfg_cols = 7'd3;
        src[0] = 8'hA1; src[1] = 8'hA2;
        pulse_frame();
        feed(0, 2, got);
        row_start = 1'b1;
        dack      = 1'b1;
        ichar     = 8'hEE;
        tick();
        row_start = 1'b0;
        dack      = 1'b0;
        check("col_underrun", 32'(underrun), 32'h1);
        read_at(1);
        check("col_rd1", 32'(rd_char), 32'hA2);
        read_at(2);
        check("col_rd2", 32'(rd_char), 32'h0);
        for (int i = 0; i < 4; i++) src[i] = 8'h31 + 8'(i);
        feed(0, 4, got);
        check("col_next_xfers", 32'(got), 32'd4);
        pulse_row();
        read_at(0);
        check("col_next_rd0", 32'(rd_char), 32'h31);
        read_at(3);
        check("col_next_rd3", 32'(rd_char), 32'h34);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
